// File: rtl/load_store_unit.sv
// load_store_unit
//   Front end of the data memory port. Takes load/store requests over a
//   valid/ready handshake. Stores go into an SB_DEPTH-entry FIFO store buffer
//   and drain to memory in order whenever the port is free. A load is answered
//   from the youngest matching buffered store (1-cycle latency) or by a memory
//   read (2-cycle latency).
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_write/addr/wdata        request payload (1 = store)
//   sb_hold                     1 blocks store drain
//   resp_valid/resp_data        load response (pulse / held data)
//   mem_address/writeData/read/write, mem_data   data memory port
//   sb_count, sb_full           store buffer occupancy
module load_store_unit #(
    parameter int          SB_DEPTH  = 4,
    parameter logic [31:0] ADDR_MASK = 32'h7ff
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    input  logic                        sb_hold,
    output logic                        resp_valid,
    output logic [31:0]                 resp_data,
    output logic [31:0]                 mem_address,
    output logic [31:0]                 mem_writeData,
    output logic                        mem_read,
    output logic                        mem_write,
    input  logic [31:0]                 mem_data,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_full
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    state_t          state;
    sb_entry_t       sb_q [SB_DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;

    logic [31:0]     masked;
    logic            fwd_hit;
    logic [31:0]     fwd_data;
    logic [PW-1:0]   idx;
    logic            is_idle, load_req, store_req;
    logic            load_issue, drain, store_acc, load_acc;

    assign masked    = req_addr & ADDR_MASK;
    assign is_idle   = (state == IDLE);
    assign load_req  = req_valid && !req_write;
    assign store_req = req_valid && req_write;
    assign sb_full   = (count == CW'(SB_DEPTH));
    assign sb_count  = count;

    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && sb_q[idx].addr == masked) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_q[idx].data;
            end
        end
    end

    // A load is always ready in IDLE, so the miss issue does not depend on
    // drain; drain then yields to it, which keeps read/write exclusive.
    assign load_issue = reset && is_idle && load_req && !fwd_hit;
    assign drain      = (count != '0) && !sb_hold && !load_issue;
    // A full buffer still takes a store when the head is leaving this cycle.
    assign req_ready  = reset && is_idle && (!req_write || !sb_full || drain);
    assign store_acc  = store_req && req_ready;
    assign load_acc   = load_req && req_ready;

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        if (load_issue) begin
            mem_read    = 1'b1;
            mem_address = masked;
        end else if (drain) begin
            mem_write     = 1'b1;
            mem_address   = sb_q[head].addr;
            mem_writeData = sb_q[head].data;
        end
    end

    // Entry storage needs no reset: validity is carried by count.
    always_ff @(posedge clk) begin
        if (store_acc) sb_q[tail] <= '{addr: masked, data: req_wdata};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_acc) begin
                        if (fwd_hit) begin
                            resp_data  <= fwd_data;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    resp_data  <= mem_data;
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (store_acc) tail <= tail + 1'b1;
            if (drain)     head <= head + 1'b1;
            count <= count + CW'(store_acc) - CW'(drain);
        end
    end
endmodule
